conv_enc_framer: RTL

//   Upstream feeder for the K=3, rate-1/2 Viterbi decoder stage.
//   - Accepts 7-bit info words over a valid/ready handshake.
//   - Convolutionally encodes each word with G0=111, G1=101, trellis starting in state 00, no tail bits.
//   - Emits the 14 coded bits serially, one per clk, in a fixed 16-cycle frame: 14 data slots + 2 idle slots.
//   - Optional per-frame error mask flips chosen coded bits for decoder verification.

---
 rtl/conv_enc_framer.sv | 101 ++++++++++
 1 files changed

// File: rtl/conv_enc_framer.sv
// conv_enc_framer: K=3 rate-1/2 convolutional encoder emitting fixed 16-slot serial frames
module conv_enc_framer #(
    parameter int         INFO_BITS = 7,
    parameter int         FRAME_LEN = 16,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INFO_BITS-1:0]   i_din,
    input  logic                   i_din_valid,
    output logic                   o_din_ready,
    input  logic [2*INFO_BITS-1:0] i_err_mask,
    output logic                   o_dout,
    output logic                   o_dout_valid,
    output logic                   o_sof,
    output logic                   o_frame_sync,
    output logic [7:0]             o_underrun_cnt
);
    localparam int              SW    = $clog2(FRAME_LEN);
    localparam int              CB    = 2*INFO_BITS;
    localparam logic [SW-1:0]   LAST  = SW'(FRAME_LEN-1);
    localparam logic [SW-1:0]   NCODE = SW'(CB);

    typedef enum logic {IDLE_FRAME, ACTIVE_FRAME} state_t;

    state_t                r_state, w_state_nxt;
    logic [SW-1:0]         r_slot, w_slot_nxt;
    logic                  r_full;
    logic [INFO_BITS-1:0]  r_pword, r_word, w_word;
    logic [CB-1:0]         r_pmask, r_mask, w_mask;
    logic                  r_s1, r_s2, w_s1, w_s2;
    logic                  w_wrap, w_u, w_dv, w_bit, w_upd;
    logic [2:0]            w_g;
    logic                  r_dout, r_dv, r_sof, r_fs;
    logic [7:0]            r_und;

    assign o_din_ready    = rst_n & ~r_full;
    assign o_dout         = r_dout;
    assign o_dout_valid   = r_dv;
    assign o_sof          = r_sof;
    assign o_frame_sync   = r_fs;
    assign o_underrun_cnt = r_und;

    // Look ahead one slot so registered outputs line up with the slot they describe
    always_comb begin
        w_wrap      = r_slot == LAST;
        w_slot_nxt  = w_wrap ? '0 : r_slot + SW'(1);
        w_state_nxt = w_wrap ? (r_full ? ACTIVE_FRAME : IDLE_FRAME) : r_state;
        w_word      = w_wrap ? r_pword : r_word;
        w_mask      = w_wrap ? r_pmask : r_mask;
        w_s1        = w_wrap ? 1'b0 : r_s1;
        w_s2        = w_wrap ? 1'b0 : r_s2;
        w_u         = |(w_word & (INFO_BITS'(1) << w_slot_nxt[SW-1:1]));
        w_g         = w_slot_nxt[0] ? G1 : G0;
        w_dv        = (w_state_nxt == ACTIVE_FRAME) && (w_slot_nxt < NCODE);
        w_bit       = w_dv & ((^(w_g & {w_u, w_s1, w_s2})) ^ (|(w_mask & (CB'(1) << w_slot_nxt))));
        w_upd       = w_dv & w_slot_nxt[0];
    end

    // Frame state register; changes only at the slot counter wrap
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE_FRAME;
        else        r_state <= w_state_nxt;
    end

    // Slot counter, pending/active buffers, trellis state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_full  <= 1'b0;
            r_pword <= '0;
            r_pmask <= '0;
            r_word  <= '0;
            r_mask  <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_dout  <= 1'b0;
            r_dv    <= 1'b0;
            r_sof   <= 1'b0;
            r_fs    <= 1'b0;
            r_und   <= '0;
        end else begin
            r_slot <= w_slot_nxt;
            r_full <= (w_wrap & r_full) ? 1'b0 : (r_full | i_din_valid);
            if (i_din_valid && !r_full) begin
                r_pword <= i_din;
                r_pmask <= i_err_mask;
            end
            r_word <= w_word;
            r_mask <= w_mask;
            r_s1   <= w_upd ? w_u : w_s1;
            r_s2   <= w_upd ? w_s1 : w_s2;
            r_dout <= w_bit;
            r_dv   <= w_dv;
            r_sof  <= w_dv && (w_slot_nxt == '0);
            r_fs   <= w_slot_nxt == '0;
            if (w_wrap && !r_full && r_und != 8'hFF) r_und <= r_und + 8'd1;
        end
    end
endmodule
